mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit in the EXE stage, beside the ALU. It takes the same forwarded operands (val1, val2) as the ALU. It computes 64-bit products or quotient/remainder over multiple cycles into HI/LO registers, which MFHI/MFLO later read through the EXE result mux. While it works, it raises `busy` so the hazard unit can stall the pipeline.

## Interface
- `WORD_LEN`, default 32: operand width; HI and LO are each `WORD_LEN` wide.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request an operation; sampled only in IDLE.
- `flush` input 1: abandon the in-flight operation, for branch/exception squash.
- `op` input `MDU_OP_LEN` (2): 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `val1` input `WORD_LEN`: multiplicand or dividend.
- `val2` input `WORD_LEN`: multiplier or divisor.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse after HI/LO are updated.
- `hi` output `WORD_LEN`: product upper half or remainder.
- `lo` output `WORD_LEN`: product lower half or quotient.

## Operation
- States:
  - IDLE: wait for a request.
  - CALC: iterate for `WORD_LEN` cycles.
  - FIX: sign correction and HI/LO writeback.
- IDLE → CALC on `start` when `flush` is low.
  - Latch `op`.
  - Latch operand magnitudes: absolute values for MULT/DIV, raw values for MULTU/DIVU.
  - Latch the result sign.
  - Clear the iteration counter.
- CALC runs one radix-2 step per cycle.
  - Multiply: shift-add into a 2×`WORD_LEN` accumulator.
  - Divide: restoring shift-subtract, with the remainder in the upper half.
  - The counter counts `WORD_LEN` steps, then the unit moves to FIX.
- FIX:
  - Apply two's-complement negation where the sign requires it.
  - Multiply: negate the full 64-bit product.
  - Divide: quotient sign = sign(val1) XOR sign(val2); remainder takes the sign of the dividend.
  - Write HI/LO, pulse `done`, return to IDLE.
- Divide by zero: no special detection. The restoring algorithm yields LO = all ones (DIVU) and HI = dividend magnitude; FIX applies the signs.
- Signed overflow (−2^(W−1) / −1): LO = 0x80000000, HI = 0.
- `start` while busy is ignored, with no queueing.
- `flush`:
  - In CALC or FIX, the unit returns to IDLE on the next edge.
  - HI/LO keep their prior values and `done` stays low.
  - `flush` together with `start` in IDLE: the request is dropped.
- HI/LO change only in FIX and on reset.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0.
- Reset mid-operation aborts immediately; no `done` is produced.
- Start accepted at edge E0, so `busy` = 1 from E0.
- CALC occupies edges E1..E`WORD_LEN`.
- FIX write happens at edge E(`WORD_LEN`+1). `hi`/`lo` are valid and `done` = 1 in the following cycle, while `busy` = 0 in that same cycle.
- Total latency is `WORD_LEN`+1 edges (33 for 32-bit), start edge to result.
- A new `start` may be accepted in the same cycle that `done` is high.
- `busy`, `done`, `hi`, `lo` are all registered; there are no combinational input-to-output paths.

## Configuration
- `MDU_DIV_EN` defined: all four ops are supported as above.
- `MDU_DIV_EN` undefined: the divide datapath is removed.
  - DIV/DIVU starts are still accepted and take the full latency.
  - FIX leaves HI/LO unchanged but still pulses `done`, so pipeline stall timing is identical.

## Structure
- Shared defines (`defines.v`, beside `WORD_LEN`): `MDU_OP_LEN`, `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`, and the state encodings `MDU_IDLE`, `MDU_CALC`, `MDU_FIX`.
- One sub-module, `mdu_step`: the combinational single-iteration step (shift-add or shift-subtract on the accumulator, selected by op). The FSM, counter and sign fixup stay in `mult_div_unit`.

## Test plan
- Reset mid-CALC, then release → `hi` = `lo` = 0, `busy` = 0, no `done`.
- MULT, val1 = 0xFFFFFFFD (−3), val2 = 7 → after 33 edges `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB, `done` 1 cycle. MULTU with the same operands → `hi` = 0x6, `lo` = 0xFFFFFFEB.
- DIV, val1 = −7, val2 = 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIVU, 100 / 7 → `lo` = 14, `hi` = 2.
- DIVU by 0, val1 = 5 → `lo` = 0xFFFFFFFF, `hi` = 5. DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- Prior result loaded, new start, `flush` at edge E10 → `busy` low after E11 (flush sampled at E10, unit in IDLE by E11), HI/LO unchanged, no `done`. A `start` pulse during busy is ignored, and exactly one `done` is seen.
- Back-to-back: `start` asserted in the `done` cycle → second result follows with no idle gap, same latency.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared opcode, state and helper definitions for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    localparam int MDU_OP_LEN = 2;

    localparam logic [MDU_OP_LEN-1:0] MDU_MULT  = 2'd0;
    localparam logic [MDU_OP_LEN-1:0] MDU_MULTU = 2'd1;
    localparam logic [MDU_OP_LEN-1:0] MDU_DIV   = 2'd2;
    localparam logic [MDU_OP_LEN-1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    // Opcode bit 1 selects divide, bit 0 selects the unsigned variant.
    function automatic logic op_is_div(input logic [MDU_OP_LEN-1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [MDU_OP_LEN-1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// Single radix-2 iteration of the multiply/divide accumulator (combinational).
// Divide step present only when MDU_DIV_EN is defined.
module mdu_step #(
    parameter int WORD_LEN = 32
) (
    input  logic                    is_div,
    input  logic [2*WORD_LEN-1:0]   acc_in,
    input  logic [WORD_LEN-1:0]     operand,
    output logic [2*WORD_LEN-1:0]   acc_out
);

    logic [WORD_LEN:0]       add_s;
    logic [2*WORD_LEN-1:0]   mul_s;
`ifdef MDU_DIV_EN
    logic [WORD_LEN:0]       sub_s;
    logic [2*WORD_LEN-1:0]   div_s;
`endif

    // Shift-add: conditionally add the multiplicand to the upper half, then shift right.
    always_comb begin
        add_s = {1'b0, acc_in[2*WORD_LEN-1:WORD_LEN]}
              + (acc_in[0] ? {1'b0, operand} : {(WORD_LEN+1){1'b0}});
        mul_s = {add_s, acc_in[WORD_LEN-1:1]};
    end

`ifdef MDU_DIV_EN
    // Restoring shift-subtract; the top bit of the trial difference is the borrow.
    always_comb begin
        sub_s = acc_in[2*WORD_LEN-1:WORD_LEN-1] - {1'b0, operand};
        if (sub_s[WORD_LEN]) begin
            div_s = {acc_in[2*WORD_LEN-2:0], 1'b0};
        end else begin
            div_s = {sub_s[WORD_LEN-1:0], acc_in[WORD_LEN-2:0], 1'b1};
        end
    end

    // Step select.
    always_comb begin
        if (is_div) begin
            acc_out = div_s;
        end else begin
            acc_out = mul_s;
        end
    end
`else
    // Without a divider the accumulator simply holds during divide ops.
    always_comb begin
        if (is_div) begin
            acc_out = acc_in;
        end else begin
            acc_out = mul_s;
        end
    end
`endif

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit writing HI/LO after WORD_LEN+1 cycles.
// Define MDU_DIV_EN to include the divide datapath; otherwise DIV/DIVU only time out.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic [MDU_OP_LEN-1:0]   op,
    input  logic [WORD_LEN-1:0]     val1,
    input  logic [WORD_LEN-1:0]     val2,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_LEN-1:0]     hi,
    output logic [WORD_LEN-1:0]     lo
);

    localparam int CNT_W = $clog2(WORD_LEN + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WORD_LEN - 1);
    localparam logic [WORD_LEN-1:0]   ONE_W    = {{(WORD_LEN-1){1'b0}}, 1'b1};
    localparam logic [2*WORD_LEN-1:0] ONE_2W   = {{(2*WORD_LEN-1){1'b0}}, 1'b1};

    mdu_state_e               state_r, state_next_s;
    logic [CNT_W-1:0]         cnt_r;
    logic                     op_div_r;
    logic                     neg_res_r;
    logic [WORD_LEN-1:0]      operand_r;
    logic [2*WORD_LEN-1:0]    acc_r, acc_step_s;
    logic                     load_s, step_s, write_s;
    logic                     sign1_s, sign2_s;
    logic [2*WORD_LEN-1:0]    prod_s;
    logic [WORD_LEN-1:0]      fix_hi_s, fix_lo_s;
    logic                     wr_en_s;
`ifdef MDU_DIV_EN
    logic                     neg_rem_r;
`endif

    function automatic logic [WORD_LEN-1:0] magnitude(input logic [WORD_LEN-1:0] v,
                                                      input logic neg);
        if (neg) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    mdu_step #(.WORD_LEN(WORD_LEN)) u_step (
        .is_div  (op_div_r),
        .acc_in  (acc_r),
        .operand (operand_r),
        .acc_out (acc_step_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MDU_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush wins over everything outside IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MDU_IDLE: begin
                if (start && !flush) begin
                    state_next_s = MDU_CALC;
                end else begin
                    state_next_s = MDU_IDLE;
                end
            end
            MDU_CALC: begin
                if (flush) begin
                    state_next_s = MDU_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = MDU_FIX;
                end else begin
                    state_next_s = MDU_CALC;
                end
            end
            MDU_FIX:  state_next_s = MDU_IDLE;
            default:  state_next_s = MDU_IDLE;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        load_s  = 1'b0;
        step_s  = 1'b0;
        write_s = 1'b0;
        case (state_r)
            MDU_IDLE: load_s  = start & ~flush;
            MDU_CALC: step_s  = ~flush;
            MDU_FIX:  write_s = ~flush;
            default: begin
                load_s  = 1'b0;
                step_s  = 1'b0;
                write_s = 1'b0;
            end
        endcase
    end

    assign sign1_s = op_is_signed(op) & val1[WORD_LEN-1];
    assign sign2_s = op_is_signed(op) & val2[WORD_LEN-1];

    // Operand latch and iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            operand_r <= {WORD_LEN{1'b0}};
            acc_r     <= {(2*WORD_LEN){1'b0}};
        end else if (load_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_div_r  <= op_is_div(op);
            neg_res_r <= sign1_s ^ sign2_s;
            operand_r <= magnitude(val2, sign2_s);
            acc_r     <= {{WORD_LEN{1'b0}}, magnitude(val1, sign1_s)};
        end else if (step_s) begin
            cnt_r     <= cnt_r + CNT_W'(1);
            acc_r     <= acc_step_s;
        end else begin
            cnt_r     <= cnt_r;
            acc_r     <= acc_r;
        end
    end

`ifdef MDU_DIV_EN
    // Remainder follows the dividend sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_rem_r <= 1'b0;
        end else if (load_s) begin
            neg_rem_r <= sign1_s;
        end else begin
            neg_rem_r <= neg_rem_r;
        end
    end
`endif

    // Sign fixup of the finished accumulator.
    always_comb begin
        if (neg_res_r) begin
            prod_s = ~acc_r + ONE_2W;
        end else begin
            prod_s = acc_r;
        end
        fix_hi_s = prod_s[2*WORD_LEN-1:WORD_LEN];
        fix_lo_s = prod_s[WORD_LEN-1:0];
        wr_en_s  = 1'b1;
        if (op_div_r) begin
`ifdef MDU_DIV_EN
            fix_lo_s = neg_res_r ? (~acc_r[WORD_LEN-1:0] + ONE_W) : acc_r[WORD_LEN-1:0];
            fix_hi_s = neg_rem_r ? (~acc_r[2*WORD_LEN-1:WORD_LEN] + ONE_W)
                                 : acc_r[2*WORD_LEN-1:WORD_LEN];
`else
            wr_en_s  = 1'b0;
`endif
        end else begin
            wr_en_s  = 1'b1;
        end
    end

    // Registered outputs; busy mirrors the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            hi   <= {WORD_LEN{1'b0}};
            lo   <= {WORD_LEN{1'b0}};
        end else begin
            busy <= (state_next_s != MDU_IDLE);
            done <= write_s;
            if (write_s && wr_en_s) begin
                hi <= fix_hi_s;
                lo <= fix_lo_s;
            end else begin
                hi <= hi;
                lo <= lo;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, corner sequences, random ops vs model.
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, flush;
    logic [1:0]    op;
    logic [W-1:0]  val1, val2;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [63:0]   prev_res;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  hi;
        logic [31:0]  lo;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    mult_div_unit #(.WORD_LEN(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .flush (flush),
        .op    (op),
        .val1  (val1),
        .val2  (val2),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: math on magnitudes, signs applied afterwards; divide-by-zero gives all-ones quotient.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint      sa, sb;
        logic [31:0] am, bm, q, r;
        logic        na, nb;
        case (o)
            2'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            2'd1: return {32'h0, a} * {32'h0, b};
            default: begin
                if (!DIV_EN) return prev;
                na = (o == 2'd2) && a[31];
                nb = (o == 2'd2) && b[31];
                am = na ? (32'd0 - a) : a;
                bm = nb ? (32'd0 - b) : b;
                if (bm == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    r = am;
                end else begin
                    q = am / bm;
                    r = am % bm;
                end
                if (na ^ nb) q = 32'd0 - q;
                if (na) r = 32'd0 - r;
                return {r, q};
            end
        endcase
    endfunction

    // Called just after a negedge; returns just after the negedge following the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        val1  = a;
        val2  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp);
        int lat;
        launch(o, a, b);
        wait_done(lat);
        chk({name, "_latency"}, 64'(lat), 64'd33);
        chk({name, "_result"}, {hi, lo}, exp);
        chk({name, "_busy_in_done"}, 64'(busy), 64'd0);
        prev_res = exp;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    initial begin
        int          lat, nd;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] e;

        tbl[0] = '{"mult_neg3x7",    2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[1] = '{"multu_neg3x7",   2'd1, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB};
        tbl[2] = '{"mult_minxmin",   2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[3] = '{"multu_maxxmax",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[4] = '{"div_neg7by2",    2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[5] = '{"divu_100by7",    2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        tbl[6] = '{"divu_5by0",      2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        tbl[7] = '{"div_overflow",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; val1 = 32'd0; val2 = 32'd0;
        prev_res = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fixed vectors, each followed by a check that done was a single-cycle pulse.
        for (int i = 0; i < 8; i++) begin
            e = (tbl[i].op[1] && !DIV_EN) ? prev_res : {tbl[i].hi, tbl[i].lo};
            run_check(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, e);
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
        end

        // Reset in the middle of CALC discards the operation and clears HI/LO.
        run_check("pre_reset", 2'd1, 32'h1234_5678, 32'd3, 64'h0000_0000_369D_0368);
        @(negedge clk);
        launch(2'd1, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midcalc_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("midcalc_reset_hilo", {hi, lo}, 64'd0);
        count_dones(40, nd);
        chk("midcalc_reset_no_done", 64'(nd), 64'd0);
        chk("midcalc_reset_idle", 64'(busy), 64'd0);
        prev_res = 64'd0;

        // Flush sampled at E10: idle by E11, HI/LO untouched, no done.
        run_check("pre_flush", 2'd0, 32'd1000, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_F830);
        @(negedge clk);
        launch(2'd1, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_low", 64'(busy), 64'd0);
        count_dones(40, nd);
        chk("flush_no_done", 64'(nd), 64'd0);
        chk("flush_hilo_kept", {hi, lo}, prev_res);

        // A start pulse while busy must be ignored.
        launch(2'd0, 32'hFFFF_FF00, 32'd300);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'd1; val1 = 32'd9; val2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        count_dones(60, nd);
        chk("busy_start_one_done", 64'(nd), 64'd1);
        e = model(2'd0, 32'hFFFF_FF00, 32'd300, prev_res);
        chk("busy_start_result", {hi, lo}, e);
        chk("busy_start_idle", 64'(busy), 64'd0);
        prev_res = e;

        // Back-to-back: second start issued in the done cycle.
        run_check("b2b_first", 2'd1, 32'd65536, 32'd65536, 64'h0000_0001_0000_0000);
        e = model(2'd3, 32'd1000, 32'd33, prev_res);
        run_check("b2b_second", 2'd3, 32'd1000, 32'd33, e);
        @(negedge clk);

        // Randomized ops against the reference model, some back-to-back.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            e = model(ro, ra, rb, prev_res);
            run_check("random", ro, ra, rb, e);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
